// File: rtl/dmem_loader.sv
// dmem_loader: byte-stream front end for the matrix-multiply core.
// Receives a length-prefixed image of little-endian 16-bit words over a
// valid/ready byte interface, writes each word into data memory starting at
// BASE_ADDR, pulses start to the core and stays busy until core_end rises.
// Optional build macro: DMEM_LOADER_CHECKSUM_EN appends a trailing XOR
// checksum byte to every frame and gates the start pulse on it.
module dmem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  dm_write,
  output logic [ADDR_WIDTH-1:0] dm_address,
  output logic [DATA_WIDTH-1:0] dm_data,
  output logic                  start,
  input  logic                  core_end,
  output logic                  busy,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_WRITE,
`ifdef DMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_START,
    S_RUN
  } state_t;

  // State entered once the last word is written (or immediately for N=0).
`ifdef DMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_START;
`endif

  state_t                  state_q;
  logic [7:0]              len_lo_q;
  logic [15:0]             len_q;
  logic [7:0]              byte_lo_q;
  logic [15:0]             cnt_q;
  logic [ADDR_WIDTH-1:0]   dm_address_q;
  logic [DATA_WIDTH-1:0]   dm_data_q;
  logic                    load_error_q;
  logic                    core_end_q;

  logic                    rx_fire;
  logic [15:0]             len_d;
  logic [15:0]             cnt_d;

  assign rx_fire = rx_valid & rx_ready;
  assign len_d   = {rx_data, len_lo_q};
  assign cnt_d   = cnt_q + 16'd1;

  // Byte acceptance window: only states that consume a frame byte are ready.
  always_comb begin
    // NOTE: default first so every path assigns rx_ready; otherwise a latch is inferred.
    rx_ready = 1'b0;
    case (state_q)
      S_IDLE, S_LEN_HI, S_DATA_LO, S_DATA_HI: rx_ready = 1'b1;
`ifdef DMEM_LOADER_CHECKSUM_EN
      S_CHECK:                                rx_ready = 1'b1;
`endif
      default:                                rx_ready = 1'b0;
    endcase
  end

  assign dm_write     = (state_q == S_WRITE);
  assign start        = (state_q == S_START);
  assign busy         = (state_q != S_IDLE);
  assign dm_address   = dm_address_q;
  assign dm_data      = dm_data_q;
  assign load_error   = load_error_q;
  assign words_loaded = cnt_q;

`ifdef DMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of every accepted frame byte; restarts on the first length byte.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      csum_q <= 8'h00;
    end else if (rx_fire) begin
      csum_q <= (state_q == S_IDLE) ? rx_data : (csum_q ^ rx_data);
    end
  end
`endif

  // Frame sequencer: length, word assembly, memory write, start and run tracking.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      len_lo_q     <= 8'h00;
      len_q        <= 16'h0000;
      byte_lo_q    <= 8'h00;
      cnt_q        <= 16'h0000;
      dm_address_q <= '0;
      dm_data_q    <= '0;
      load_error_q <= 1'b0;
      core_end_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      core_end_q <= core_end;
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            len_lo_q     <= rx_data;
            cnt_q        <= 16'h0000;
            load_error_q <= 1'b0;
            state_q      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_fire) begin
            len_q <= len_d;
            if ({1'b0, len_d} > 17'(MAX_WORDS)) begin
              load_error_q <= 1'b1;
              state_q      <= S_IDLE;
            end else if (len_d == 16'h0000) begin
              state_q <= S_TAIL;
            end else begin
              state_q <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (rx_fire) begin
            byte_lo_q <= rx_data;
            state_q   <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (rx_fire) begin
            // Address wraps modulo 2^ADDR_WIDTH by truncation.
            dm_address_q <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(cnt_q);
            dm_data_q    <= DATA_WIDTH'({rx_data, byte_lo_q});
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q   <= cnt_d;
          state_q <= (cnt_d == len_q) ? S_TAIL : S_DATA_LO;
        end
`ifdef DMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_fire) begin
            if (rx_data == csum_q) begin
              state_q <= S_START;
            end else begin
              load_error_q <= 1'b1;
              state_q      <= S_IDLE;
            end
          end
        end
`endif
        S_START: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          // Only a fresh 0->1 of core_end ends the run.
          if (core_end && !core_end_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: directed self-checking bench for dmem_loader.
// BASE_ADDR is set to 0xFFFF so the second word of any image lands on the
// wrapped address 0x0000. Builds with and without DMEM_LOADER_CHECKSUM_EN.
module tb_dmem_loader;

  localparam int BASE = 16'hFFFF;
`ifdef DMEM_LOADER_CHECKSUM_EN
  localparam int START_LAT = 2;
`else
  localparam int START_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        RESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        dm_write;
  logic [15:0] dm_address;
  logic [15:0] dm_data;
  logic        start;
  logic        core_end;
  logic        busy;
  logic        load_error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  int          start_cnt  = 0;
  int          start_cyc  = 0;
  logic        start_prev = 1'b0;
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  dmem_loader #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .BASE_ADDR (BASE),
    .MAX_WORDS (256)
  ) dut (
    .clk         (clk),
    .RESET       (RESET),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .dm_write    (dm_write),
    .dm_address  (dm_address),
    .dm_data     (dm_data),
    .start       (start),
    .core_end    (core_end),
    .busy        (busy),
    .load_error  (load_error),
    .words_loaded(words_loaded)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs writes and start pulses, checks write/ready exclusivity.
  always @(negedge clk) begin
    if (dm_write) begin
      wr_addr.push_back(dm_address);
      wr_data.push_back(dm_data);
      wr_cyc.push_back(cyc);
      check("rdy_in_write", 32'(rx_ready), 32'd0);
    end
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
      check("start_width", 32'(start_prev), 32'd0);
    end
    start_prev = start;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      done = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    check("rx_accept", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input bit gaps);
`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    foreach (frame[i]) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
      x ^= frame[i];
`endif
      send_byte(frame[i], gaps ? int'($urandom_range(0, 3)) : 0);
    end
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(x, gaps ? int'($urandom_range(0, 3)) : 0);
`endif
  endtask

  task automatic wait_start(input int exp);
    int n;
    n = 0;
    while (start_cnt < exp && n < 40) begin @(posedge clk); #1; n++; end
    check("start_seen", start_cnt, exp);
  endtask

  // Called in RUN with core_end low for at least one edge.
  task automatic end_run();
    check("busy_run", 32'(busy), 32'd1);
    check("rdy_run", 32'(rx_ready), 32'd0);
    core_end = 1'b1;
    @(negedge clk);
    check("busy_pre_end", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_after_end", 32'(busy), 32'd0);
    check("rdy_after_end", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    core_end = 1'b0;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RESET    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    core_end = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rdy", 32'(rx_ready), 32'd1);
    check("rst_write", 32'(dm_write), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_addr", 32'(dm_address), 32'd0);
    check("rst_data", 32'(dm_data), 32'd0);
    #2 RESET = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: async reset while in DATA_HI of the second word
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check("s1_words_pre", 32'(words_loaded), 32'd1);
    check("s1_busy_pre", 32'(busy), 32'd1);
    #2 RESET = 1'b1;
    #1 RESET = 1'b0;
    @(negedge clk);
    check("s1_rdy", 32'(rx_ready), 32'd1);
    check("s1_busy", 32'(busy), 32'd0);
    check("s1_start", 32'(start), 32'd0);
    check("s1_write", 32'(dm_write), 32'd0);
    check("s1_words", 32'(words_loaded), 32'd0);
    check("s1_nostart", start_cnt, 0);
    @(posedge clk); #1;
    clear_log();
    frame = '{8'h01, 8'h00, 8'hAA, 8'h55};
    send_frame(1'b0);
    wait_start(1);
    check("s1_nwr", wr_addr.size(), 1);
    check("s1_addr", 32'(wr_addr[0]), 32'hFFFF);
    check("s1_data", 32'(wr_data[0]), 32'h55AA);
    check("s1_words_post", 32'(words_loaded), 32'd1);
    end_run();

    // Scenario 2: two words back to back, address wraps
    clear_log();
    frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(1'b0);
    wait_start(2);
    check("s2_nwr", wr_addr.size(), 2);
    check("s2_addr0", 32'(wr_addr[0]), 32'hFFFF);
    check("s2_data0", 32'(wr_data[0]), 32'h1234);
    check("s2_addr1", 32'(wr_addr[1]), 32'h0000);
    check("s2_data1", 32'(wr_data[1]), 32'h5678);
    check("s2_wr_gap", wr_cyc[1] - wr_cyc[0], 3);
    check("s2_start_lat", start_cyc - wr_cyc[1], START_LAT);
    check("s2_words", 32'(words_loaded), 32'd2);
    tick(3);
    check("s2_busy_hold", 32'(busy), 32'd1);
    end_run();

    // Scenario 3: empty image, core_end already high when RUN is entered
    core_end = 1'b1;
    tick(1);
    clear_log();
    frame = '{8'h00, 8'h00};
    send_frame(1'b0);
    wait_start(3);
    check("s3_nwr", wr_addr.size(), 0);
    check("s3_words", 32'(words_loaded), 32'd0);
    tick(3);
    check("s3_busy_level", 32'(busy), 32'd1);
    core_end = 1'b0;
    tick(1);
    end_run();

    // Scenario 4: N=257 rejected, next frame clears the error
    clear_log();
    send_byte(8'h01, 0);
    check("s4_busy_len", 32'(busy), 32'd1);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("s4_err", 32'(load_error), 32'd1);
    check("s4_busy", 32'(busy), 32'd0);
    check("s4_rdy", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    tick(3);
    check("s4_nostart", start_cnt, 3);
    check("s4_nwr", wr_addr.size(), 0);
    send_byte(8'h01, 0);
    check("s4_err_clr", 32'(load_error), 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
`ifdef DMEM_LOADER_CHECKSUM_EN
    send_byte(8'h50, 0);
`endif
    wait_start(4);
    check("s4_addr", 32'(wr_addr[0]), 32'hFFFF);
    check("s4_data", 32'(wr_data[0]), 32'hBEEF);
    end_run();

    // Scenario 5: random valid gaps give the same image as scenario 2
    clear_log();
    frame = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(1'b1);
    wait_start(5);
    check("s5_nwr", wr_addr.size(), 2);
    check("s5_addr0", 32'(wr_addr[0]), 32'hFFFF);
    check("s5_data0", 32'(wr_data[0]), 32'h1234);
    check("s5_addr1", 32'(wr_addr[1]), 32'h0000);
    check("s5_data1", 32'(wr_data[1]), 32'h5678);
    end_run();

    // Boundary: N=MAX_WORDS=256 is accepted
    clear_log();
    frame = '{8'h00, 8'h01};
    for (int k = 0; k < 256; k++) begin
      frame.push_back(8'(k));
      frame.push_back(8'h00);
    end
    send_frame(1'b0);
    wait_start(6);
    check("max_nwr", wr_addr.size(), 256);
    check("max_addr_last", 32'(wr_addr[255]), 32'h00FE);
    check("max_data_last", 32'(wr_data[255]), 32'h00FF);
    check("max_words", 32'(words_loaded), 32'h100);
    check("max_err", 32'(load_error), 32'd0);
    end_run();

`ifdef DMEM_LOADER_CHECKSUM_EN
    // Scenario 6: good and bad checksum
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hAB, 0);
    send_byte(8'h67, 0);
    wait_start(7);
    check("s6_data_ok", 32'(wr_data[0]), 32'hABCD);
    end_run();
    clear_log();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hCD, 0);
    send_byte(8'hAB, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("s6_err", 32'(load_error), 32'd1);
    check("s6_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    tick(3);
    check("s6_nostart", start_cnt, 7);
    check("s6_nwr", wr_addr.size(), 1);
    check("s6_addr", 32'(wr_addr[0]), 32'hFFFF);
    check("s6_data", 32'(wr_data[0]), 32'hABCD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
